// File: rtl/pending_arbiter_rr.sv
// pending_arbiter_rr
// N-channel arbiter that accumulates single-cycle request pulses as per-channel
// pending credits and services one credit per enabled cycle with a registered
// one-hot grant. Ordering is fixed priority (bit 0 highest) or round-robin
// starting after the last granted channel.
//
// Optional feature macro: ARB_OVF_EN
//   defined   -> ports ovf / ovf_clr exist; ovf is a sticky flag set whenever a
//                request is dropped because its channel counter is saturated.
//   undefined -> no ovf / ovf_clr ports; dropped requests are discarded silently.
//
// Handshake: there is no back-pressure. A high req bit in a cycle is one credit
// offered and always accepted (unless the counter is saturated). grant is valid
// for exactly the cycle it is high, and grant_vld mirrors |grant.
module pending_arbiter_rr #(
  parameter int N     = 4,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] req,
  input  logic         enable,
  input  logic         mode,
`ifdef ARB_OVF_EN
  input  logic         ovf_clr,
  output logic         ovf,
`endif
  output logic [N-1:0] grant,
  output logic         grant_vld,
  output logic         pend_any
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     grant_q, grant_d;
  logic             grant_vld_q, grant_vld_d;
  logic             pend_any_q, pend_any_d;

  logic [N-1:0]     elig;
  logic             win_vld;
  logic [PTR_W-1:0] win_idx;

  // Channel index k steps after base, wrapping modulo N.
  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int k);
    int j;
    j = int'(base) + k;
    if (j >= N) j = j - N;
    return PTR_W'(j);
  endfunction

  // A channel competes if it holds credit or is requesting this cycle.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      elig[i] = (cnt_q[i] != '0) | req[i];
    end
  end

  // Winner pick: loops run from lowest to highest priority so the last hit wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    if (enable) begin
      if (!mode) begin
        for (int i = N - 1; i >= 0; i--) begin
          if (elig[i]) begin
            win_vld = 1'b1;
            win_idx = PTR_W'(i);
          end
        end
      end else begin
        // k = 1 (channel right after the pointer) is highest priority,
        // k = N (the pointer itself) lowest.
        for (int k = N; k >= 1; k--) begin
          if (elig[rr_idx(ptr_q, k)]) begin
            win_vld = 1'b1;
            win_idx = rr_idx(ptr_q, k);
          end
        end
      end
    end
  end

  // Credit bookkeeping: winner spends one credit, others saturate on add.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (win_vld && (win_idx == PTR_W'(i))) begin
        // Modular arithmetic keeps a saturated winner with req at max (net 0).
        cnt_d[i] = cnt_q[i] + CNT_W'(req[i]) - CNT_W'(1);
      end else if (req[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Next-state for grant, pointer and pending summary.
  always_comb begin
    grant_d     = '0;
    grant_vld_d = win_vld;
    ptr_d       = ptr_q;
    pend_any_d  = 1'b0;
    if (win_vld) begin
      grant_d[win_idx] = 1'b1;
      ptr_d            = win_idx;
    end
    for (int i = 0; i < N; i++) begin
      pend_any_d = pend_any_d | (cnt_d[i] != '0);
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
      ptr_q       <= PTR_W'(N - 1);
      grant_q     <= '0;
      grant_vld_q <= 1'b0;
      pend_any_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      grant_vld_q <= grant_vld_d;
      pend_any_q  <= pend_any_d;
    end
  end

  assign grant     = grant_q;
  assign grant_vld = grant_vld_q;
  assign pend_any  = pend_any_q;

`ifdef ARB_OVF_EN
  logic drop;
  logic ovf_q, ovf_d;

  // A request is dropped when its non-winning channel is already at max.
  always_comb begin
    drop = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (cnt_q[i] == CNT_MAX) && !(win_vld && (win_idx == PTR_W'(i)))) begin
        drop = 1'b1;
      end
    end
    // Set has priority over clear.
    ovf_d = drop | (ovf_q & ~ovf_clr);
  end

  // Sticky overflow flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pending_arbiter_rr.sv
// Bench for pending_arbiter_rr: directed scenarios followed by random traffic,
// checked through an expected-value queue against a credit-count model.
module tb_pending_arbiter_rr;

  localparam int N     = 4;
  localparam int CNT_W = 2;
  localparam int W     = N + 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic [N-1:0] req;
  logic         enable;
  logic         mode;
  logic         ovf_clr;
  logic [N-1:0] grant;
  logic         grant_vld;
  logic         pend_any;
  logic         ovf_s;

`ifdef ARB_OVF_EN
  logic ovf;
  assign ovf_s = ovf;
`else
  assign ovf_s = 1'b0;
`endif

  pending_arbiter_rr #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .enable    (enable),
    .mode      (mode),
`ifdef ARB_OVF_EN
    .ovf_clr   (ovf_clr),
    .ovf       (ovf),
`endif
    .grant     (grant),
    .grant_vld (grant_vld),
    .pend_any  (pend_any)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int vectors    = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  int m_cnt[N];
  int m_ptr;
  bit m_ovf;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr = N - 1;
    m_ovf = 1'b0;
  endtask

  // Applies one edge to the model and returns {ovf, pend_any, grant_vld, grant}.
  task automatic model_step(input logic [N-1:0] r, input logic en, input logic md,
                            input logic clr, output logic [W-1:0] e);
    int win;
    int best;
    int d;
    bit drop;
    bit pend;
    logic [N-1:0] g;
    win  = -1;
    best = N + 1;
    drop = 1'b0;
    pend = 1'b0;
    g    = '0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        if (m_cnt[i] > 0 || r[i]) begin
          // Distance from the channel after the pointer in rr mode; raw index otherwise.
          d = md ? ((i - m_ptr - 1 + 2 * N) % N) : i;
          if (d < best) begin
            best = d;
            win  = i;
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (i == win) m_cnt[i] = m_cnt[i] + int'(r[i]) - 1;
      else if (r[i]) begin
        if (m_cnt[i] == CMAX) drop = 1'b1;
        else m_cnt[i] = m_cnt[i] + 1;
      end
      if (m_cnt[i] > 0) pend = 1'b1;
    end
    if (win >= 0) begin
      m_ptr  = win;
      g[win] = 1'b1;
    end
`ifdef ARB_OVF_EN
    m_ovf = drop || (m_ovf && !clr);
`else
    m_ovf = 1'b0;
`endif
    e = {m_ovf, pend, (win >= 0), g};
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [N-1:0] r, input logic en, input logic md, input logic clr);
    logic [W-1:0] e;
    @(negedge clk);
    req     = r;
    enable  = en;
    mode    = md;
    ovf_clr = clr;
    model_step(r, en, md, clr, e);
    exp_q.push_back(e);
  endtask

  task automatic check_direct(input string name, input logic [W-1:0] e);
    logic [W-1:0] act;
    act = {ovf_s, pend_any, grant_vld, grant};
    vectors++;
    if (act !== e) begin
      miscompares++;
      $display("FAIL %s t=%0t got {ovf,pend,vld,grant}=%b expected %b", name, $time, act, e);
    end
  endtask

  // Async reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    rstn    = 1'b0;
    req     = '0;
    enable  = 1'b0;
    ovf_clr = 1'b0;
    #1;
    check_direct("async_reset", '0);
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {ovf_s, pend_any, grant_vld, grant};
        vectors++;
        if (mon_act !== mon_exp) begin
          miscompares++;
          $display("FAIL edge_check t=%0t got {ovf,pend,vld,grant}=%b expected %b",
                   $time, mon_act, mon_exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [N-1:0] rr;
  logic         ren;
  logic         rmd;
  logic         rclr;

  initial begin
    rstn    = 1'b0;
    req     = '0;
    enable  = 1'b0;
    mode    = 1'b0;
    ovf_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_direct("reset_state", '0);
    @(negedge clk);
    rstn = 1'b1;

    // Fixed priority drain of a single multi-bit pulse.
    cycle(4'b1011, 1'b1, 1'b0, 1'b0);
    repeat (4) cycle(4'b0000, 1'b1, 1'b0, 1'b0);

    // Accumulate while disabled, then drain in fixed order.
    cycle(4'b1000, 1'b0, 1'b0, 1'b0);
    cycle(4'b0010, 1'b0, 1'b0, 1'b0);
    cycle(4'b1010, 1'b0, 1'b0, 1'b0);
    cycle(4'b1000, 1'b0, 1'b0, 1'b0);
    repeat (7) cycle(4'b0000, 1'b1, 1'b0, 1'b0);

    // Round-robin rotation from reset over 12 credits.
    do_reset();
    repeat (3) cycle(4'b1111, 1'b1, 1'b1, 1'b0);
    repeat (11) cycle(4'b0000, 1'b1, 1'b1, 1'b0);

    // Single streaming channel with one interloper.
    repeat (4) cycle(4'b0100, 1'b1, 1'b1, 1'b0);
    cycle(4'b0101, 1'b1, 1'b1, 1'b0);
    repeat (3) cycle(4'b0100, 1'b1, 1'b1, 1'b0);
    repeat (2) cycle(4'b0000, 1'b1, 1'b1, 1'b0);

    // Saturation, drop+clear in the same cycle, then clear, then drain.
    repeat (5) cycle(4'b0010, 1'b0, 1'b0, 1'b0);
    cycle(4'b0010, 1'b0, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b0, 1'b1);
    repeat (5) cycle(4'b0000, 1'b1, 1'b0, 1'b0);

    // Saturated winner with a concurrent request keeps its count.
    repeat (4) cycle(4'b0001, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(4'b0001, 1'b1, 1'b0, 1'b0);
    repeat (4) cycle(4'b0000, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a round-robin burst, then lowest eligible first.
    repeat (3) cycle(4'b1111, 1'b1, 1'b1, 1'b0);
    do_reset();
    cycle(4'b0110, 1'b1, 1'b1, 1'b0);
    repeat (3) cycle(4'b0000, 1'b1, 1'b1, 1'b0);

    // Random traffic: heavy enough to saturate, with mode flips and enable gaps.
    rmd = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) rr[i] = ($urandom_range(0, 9) < 3);
      ren  = ($urandom_range(0, 9) != 0);
      rclr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) rmd = ~rmd;
      cycle(rr, ren, rmd, rclr);
      if ($urandom_range(0, 599) == 0) do_reset();
    end
    repeat (8) cycle(4'b0000, 1'b1, rmd, 1'b0);

    // Let the monitor consume the remaining expectations, bounded.
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout got %0d pending expectations expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pending_arbiter_rr.md
Name: pending_arbiter_rr

Overview:
Parametrised N-channel arbiter with per-channel pending-request counters and selectable fixed-priority or round-robin ordering. It is the generalised successor of the 4-channel fixed-order pending arbiter. Single-cycle request pulses are accumulated as pending credits, and one credit is serviced per enabled cycle with a registered one-hot grant. It sits between request sources (DMA or register-access initiators) and a shared single-ported resource.

Parameters:
N, 4, number of request channels (2..16)
CNT_W, 4, pending counter width per channel; max pending per channel = 2^CNT_W-1

Ports:
clk  input  1  clock, rising-edge
rstn  input  1  reset, asynchronous, active-low
req  input  N  request pulses; each high bit adds one pending credit to its channel per cycle
enable  input  1  arbitration enable; when low no grants are issued, requests still accumulate
mode  input  1  0 = fixed priority (bit 0 highest), 1 = round-robin
grant  output  N  registered one-hot grant, or all-zero
grant_vld  output  1  registered; equals |grant
pend_any  output  1  registered; high when any pending counter is non-zero
ovf  output  1  sticky overflow flag (only with ARB_OVF_EN)
ovf_clr  input  1  synchronous clear of ovf (only with ARB_OVF_EN)

Behaviour:
- Reset (rstn low, async): all cnt[i]=0, grant=0, grant_vld=0, pend_any=0, rr pointer ptr=N-1, ovf=0. Release is synchronous to clk.
- Each posedge, sampled values: elig[i] = (cnt[i]!=0) | req[i].
- Winner selection when enable=1 and |elig:
  - mode=0: lowest index with elig set.
  - mode=1: first elig index searching ptr+1, ptr+2, ... with wrap modulo N.
- Update on a winning cycle:
  - grant <= onehot(w); cnt[w] <= cnt[w] + req[w] - 1.
  - All other channels: cnt[i] <= sat(cnt[i] + req[i]).
  - ptr <= w, updated in both modes. A later switch to mode=1 resumes after the last grant.
- No winner (enable=0 or no elig): grant <= 0 and all counters take sat(cnt+req).
- Latency: a req pulse at edge k can produce a grant visible after edge k, i.e. one cycle minimum.
- Throughput: at most one grant per cycle. Back-to-back grants to the same channel are allowed while its cnt>0.
- Saturation: cnt[i]==max with req[i]=1 and i not granted -> request dropped, cnt stays max. Granted at max with req -> cnt stays max (net 0).
- pend_any <= OR over next-state counters, i.e. remaining credits after this cycle's grant.
- Mode change takes effect at the next arbitration edge. Counters are not disturbed.
- Dropping enable mid-burst: grant goes to 0 after the next edge and credits are retained. Servicing resumes in the correct order when enable returns.
- grant is never multi-hot.

Optional Feature:
ARB_OVF_EN
- Defined: ports ovf and ovf_clr exist.
  - ovf is set on any dropped request (saturation case above).
  - ovf_clr=1 clears ovf at the next edge.
  - A simultaneous drop and clear leaves ovf=1 (set wins).
- Undefined: neither port exists, and dropped requests are silently discarded. All other behaviour is identical.

Test Plan:
1. N=4, mode=0, enable=1, single-cycle req=4'b1011 -> grant 0001, 0010, 1000 on three consecutive cycles, then 0000; pend_any low after the third grant.
2. enable=0, req pulses 1000, 0010, 1010, 1000 over four cycles; grant stays 0, cnt[3]=3, cnt[1]=2. Then raise enable with mode=0 -> grant sequence 0010, 0010, 1000, 1000, 1000.
3. mode=1, req=4'b1111 held 3 cycles from reset -> grants rotate 0001, 0010, 0100, 1000, 0001, ... until all 12 credits are drained.
4. mode=1 with only channel 2 active (req=0100 each cycle) -> grant=0100 every cycle, cnt[2] stays 0. Add req[0] for one cycle -> channel 0 is granted once, then channel 2 resumes.
5. CNT_W=2, enable=0, req[1] pulsed 5 times -> cnt[1]=3 and, with ARB_OVF_EN, ovf=1. Assert ovf_clr -> ovf=0. Enable -> exactly 3 grants of 0010.
6. Assert rstn low mid-burst with cnt non-zero and grant active -> grant, grant_vld, pend_any and ovf drop to 0 immediately (async). After release, the first round-robin grant goes to the lowest elig index.
